packet_rx_writer: RTL and testbench

// Ethernet RX front-end feeding the packet buffer's write (TX-side) port. Takes the MAC's

---
 rtl/packet_rx_writer_pkg.sv | 16 +
 rtl/packet_rx_writer_if.sv | 35 +++
 rtl/packet_rx_writer_word_packer.sv | 38 +++
 rtl/packet_rx_writer.sv | 144 ++++++++++++++
 tb/tb_packet_rx_writer.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/packet_rx_writer_pkg.sv
// Shared definitions for the Ethernet RX packet writer: FSM states and the
// full-word write-size code for a given buffer word width.
package packet_rx_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } rx_state_e;

    // Buffer encodes a full-word write as 2'b11 on 64-bit words, 2'b10 on 32-bit words.
    function automatic logic [1:0] wdata_size_code(input int unsigned width);
        return (width == 64) ? 2'b11 : 2'b10;
    endfunction

endpackage

// File: rtl/packet_rx_writer_if.sv
// MAC byte stream plus packet-buffer write port. master = the RX writer,
// slave = the MAC/buffer side that drives bytes and consumes writes.
interface packet_rx_writer_if #(
    parameter int unsigned data_width_p = 64,
    parameter int unsigned els_p        = 2048
);
    localparam int unsigned addr_width_lp = $clog2(els_p);
    localparam int unsigned size_width_lp = $clog2(els_p + 1);

    logic                     rx_valid_i;
    logic [7:0]               rx_data_i;
    logic                     rx_last_i;
    logic                     rx_error_i;
    logic                     packet_req_i;
    logic                     packet_wvalid_o;
    logic [addr_width_lp-1:0] packet_waddr_o;
    logic [data_width_p-1:0]  packet_wdata_o;
    logic [1:0]               packet_wdata_size_o;
    logic                     packet_wsize_valid_o;
    logic [size_width_lp-1:0] packet_wsize_o;
    logic                     packet_send_o;

    modport master (
        input  rx_valid_i, rx_data_i, rx_last_i, rx_error_i, packet_req_i,
        output packet_wvalid_o, packet_waddr_o, packet_wdata_o, packet_wdata_size_o,
               packet_wsize_valid_o, packet_wsize_o, packet_send_o
    );

    modport slave (
        output rx_valid_i, rx_data_i, rx_last_i, rx_error_i, packet_req_i,
        input  packet_wvalid_o, packet_waddr_o, packet_wdata_o, packet_wdata_size_o,
               packet_wsize_valid_o, packet_wsize_o, packet_send_o
    );

endinterface

// File: rtl/packet_rx_writer_word_packer.sv
// Byte-to-word packer: merges each byte at its lane offset and clears itself
// once a word is handed off (full word or frame end) or a frame is abandoned.
module packet_rx_writer_word_packer #(
    parameter int unsigned data_width_p = 64
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  valid_i,
    input  logic                                  clr_i,
    input  logic                                  last_i,
    input  logic [$clog2(data_width_p/8)-1:0]     offset_i,
    input  logic [7:0]                            data_i,
    output logic [data_width_p-1:0]               word_c,
    output logic                                  done_c
);
    localparam int unsigned bytes_lp = data_width_p / 8;
    localparam int unsigned lsb_lp   = $clog2(bytes_lp);

    logic [data_width_p-1:0] word_r;

    // Merged view including the current byte, so the caller can register it this cycle.
    always_comb begin
        word_c = word_r;
        if (valid_i) begin
            word_c[{offset_i, 3'b000} +: 8] = data_i;
        end
        done_c = valid_i && (offset_i == lsb_lp'(bytes_lp - 1));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || clr_i) begin
            word_r <= '0;
        end else if (valid_i) begin
            word_r <= (done_c || last_i) ? '0 : word_c;
        end
    end

endmodule

// File: rtl/packet_rx_writer.sv
// Ethernet RX front-end: packs MAC bytes into buffer words, commits good frames
// with their size, and drops/counts frames that are unbuffered, errored or oversize.
module packet_rx_writer
    import packet_rx_writer_pkg::*;
#(
    parameter int unsigned data_width_p     = 64,
    parameter int unsigned els_p            = 2048,
    parameter int unsigned drop_cnt_width_p = 16
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    packet_rx_writer_if.master          bus,
    output logic                        drop_o,
    output logic [drop_cnt_width_p-1:0] drop_count_o
);
    localparam int unsigned bytes_lp      = data_width_p / 8;
    localparam int unsigned lsb_lp        = $clog2(bytes_lp);
    localparam int unsigned addr_width_lp = $clog2(els_p);
    localparam int unsigned size_width_lp = $clog2(els_p + 1);
    localparam logic [addr_width_lp-1:0] addr_mask_lp = ~addr_width_lp'(bytes_lp - 1);

    rx_state_e                  state_r, state_n;
    logic [size_width_lp-1:0]   cnt_r, cnt_n, cnt_base;
    logic                       wvalid_r, wvalid_n;
    logic [addr_width_lp-1:0]   waddr_r, waddr_n;
    logic [data_width_p-1:0]    wdata_r, wdata_n;
    logic [1:0]                 wdata_size_r;
    logic                       wsize_valid_r, wsize_valid_n;
    logic [size_width_lp-1:0]   wsize_r, wsize_n;
    logic                       send_r, send_n;
    logic                       drop_r, drop_n;
    logic [drop_cnt_width_p-1:0] drop_cnt_r;
    logic                       accept;
    logic                       pack_en, pack_clr;
    logic                       word_done_c;
    logic [data_width_p-1:0]    word_c;

    packet_rx_writer_word_packer #(
        .data_width_p (data_width_p)
    ) u_packer (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .valid_i  (pack_en),
        .clr_i    (pack_clr),
        .last_i   (bus.rx_last_i),
        .offset_i (cnt_base[lsb_lp-1:0]),
        .data_i   (bus.rx_data_i),
        .word_c   (word_c),
        .done_c   (word_done_c)
    );

    // Next state and next output values; every MAC byte is consumed the cycle it arrives.
    always_comb begin
        state_n       = state_r;
        cnt_n         = cnt_r;
        wvalid_n      = 1'b0;
        waddr_n       = waddr_r;
        wdata_n       = wdata_r;
        wsize_valid_n = 1'b0;
        wsize_n       = wsize_r;
        send_n        = 1'b0;
        drop_n        = 1'b0;
        pack_en       = 1'b0;
        pack_clr      = 1'b0;
        cnt_base      = (state_r == ST_IDLE) ? '0 : cnt_r;

        case (state_r)
            ST_IDLE: accept = bus.packet_req_i && !send_r && !bus.rx_error_i;
            ST_RECV: accept = !bus.rx_error_i && (cnt_r != size_width_lp'(els_p));
            default: accept = 1'b0;
        endcase

        if (bus.rx_valid_i) begin
            if (accept) begin
                pack_en = 1'b1;
                cnt_n   = cnt_base + size_width_lp'(1);
                state_n = ST_RECV;
                if (word_done_c || bus.rx_last_i) begin
                    wvalid_n = 1'b1;
                    waddr_n  = addr_width_lp'(cnt_base) & addr_mask_lp;
                    wdata_n  = word_c;
                end
                if (bus.rx_last_i) begin
                    wsize_valid_n = 1'b1;
                    wsize_n       = cnt_base + size_width_lp'(1);
                    send_n        = 1'b1;
                    state_n       = ST_IDLE;
                    cnt_n         = '0;
                end
            end else begin
                // Rejected, errored, oversize or already-dropping frame: discard to the end.
                pack_clr = 1'b1;
                cnt_n    = '0;
                if (bus.rx_last_i) begin
                    state_n = ST_IDLE;
                    drop_n  = 1'b1;
                end else begin
                    state_n = ST_DROP;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r       <= ST_IDLE;
            cnt_r         <= '0;
            wvalid_r      <= 1'b0;
            waddr_r       <= '0;
            wdata_r       <= '0;
            wdata_size_r  <= 2'b00;
            wsize_valid_r <= 1'b0;
            wsize_r       <= '0;
            send_r        <= 1'b0;
            drop_r        <= 1'b0;
            drop_cnt_r    <= '0;
        end else begin
            state_r       <= state_n;
            cnt_r         <= cnt_n;
            wvalid_r      <= wvalid_n;
            waddr_r       <= waddr_n;
            wdata_r       <= wdata_n;
            wdata_size_r  <= wdata_size_code(data_width_p);
            wsize_valid_r <= wsize_valid_n;
            wsize_r       <= wsize_n;
            send_r        <= send_n;
            drop_r        <= drop_n;
            if (drop_n && (drop_cnt_r != '1)) begin
                drop_cnt_r <= drop_cnt_r + drop_cnt_width_p'(1);
            end
        end
    end

    assign bus.packet_wvalid_o      = wvalid_r;
    assign bus.packet_waddr_o       = waddr_r;
    assign bus.packet_wdata_o       = wdata_r;
    assign bus.packet_wdata_size_o  = wdata_size_r;
    assign bus.packet_wsize_valid_o = wsize_valid_r;
    assign bus.packet_wsize_o       = wsize_r;
    assign bus.packet_send_o        = send_r;
    assign drop_o                   = drop_r;
    assign drop_count_o             = drop_cnt_r;

endmodule

// File: tb/tb_packet_rx_writer.sv
// Directed bench for packet_rx_writer: a 64-bit and a 32-bit instance see the same
// MAC stream; buffer writes are logged on the falling edge and checked per scenario.
module tb_packet_rx_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_last = 1'b0;
    logic       rx_error = 1'b0;
    logic       req = 1'b1;

    logic        drop64, drop32;
    logic [15:0] dcnt64, dcnt32;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int last_cyc = 0;

    int          wa64_q[$];
    logic [63:0] wd64_q[$];
    int          ws64_q[$];
    int          wa32_q[$];
    logic [31:0] wd32_q[$];
    int          ws32_q[$];
    int send64 = 0, send32 = 0, dropp64 = 0, badcommit64 = 0, send_cyc64 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    packet_rx_writer_if #(.data_width_p(64), .els_p(2048)) if64 ();
    packet_rx_writer_if #(.data_width_p(32), .els_p(2048)) if32 ();

    assign if64.rx_valid_i = rx_valid;
    assign if64.rx_data_i = rx_data;
    assign if64.rx_last_i = rx_last;
    assign if64.rx_error_i = rx_error;
    assign if64.packet_req_i = req;
    assign if32.rx_valid_i = rx_valid;
    assign if32.rx_data_i = rx_data;
    assign if32.rx_last_i = rx_last;
    assign if32.rx_error_i = rx_error;
    assign if32.packet_req_i = req;

    packet_rx_writer #(.data_width_p(64), .els_p(2048), .drop_cnt_width_p(16)) dut64 (
        .clk_i(clk), .reset_i(reset), .bus(if64), .drop_o(drop64), .drop_count_o(dcnt64)
    );
    packet_rx_writer #(.data_width_p(32), .els_p(2048), .drop_cnt_width_p(16)) dut32 (
        .clk_i(clk), .reset_i(reset), .bus(if32), .drop_o(drop32), .drop_count_o(dcnt32)
    );

    // Log buffer-side activity away from the active edge.
    always @(negedge clk) begin
        if (if64.packet_wvalid_o) begin
            wa64_q.push_back(int'(if64.packet_waddr_o));
            wd64_q.push_back(if64.packet_wdata_o);
        end
        if (if64.packet_wsize_valid_o) ws64_q.push_back(int'(if64.packet_wsize_o));
        if (if64.packet_send_o) begin
            send64 = send64 + 1;
            send_cyc64 = cyc;
            if (!(if64.packet_wvalid_o && if64.packet_wsize_valid_o)) badcommit64 = badcommit64 + 1;
        end
        if (drop64) dropp64 = dropp64 + 1;
        if (if32.packet_wvalid_o) begin
            wa32_q.push_back(int'(if32.packet_waddr_o));
            wd32_q.push_back(if32.packet_wdata_o);
        end
        if (if32.packet_wsize_valid_o) ws32_q.push_back(int'(if32.packet_wsize_o));
        if (if32.packet_send_o) send32 = send32 + 1;
    end

    task automatic drive_frame(input int len, input logic [7:0] first, input bit err_last, input int idle);
        for (int i = 0; i < len; i++) begin
            @(posedge clk);
            #1;
            rx_valid = 1'b1;
            rx_data  = first + 8'(i);
            rx_last  = (i == len - 1);
            rx_error = err_last && (i == len - 1);
            if (i == len - 1) last_cyc = cyc;
        end
        if (idle > 0) begin
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
            rx_last  = 1'b0;
            rx_error = 1'b0;
            for (int j = 1; j < idle; j++) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({if64.packet_wvalid_o, if64.packet_wsize_valid_o, if64.packet_send_o, drop64} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_strobes: got %b expected 0000",
                     {if64.packet_wvalid_o, if64.packet_wsize_valid_o, if64.packet_send_o, drop64});
        end
        tests_run++;
        if (dcnt64 !== 16'd0 || if64.packet_wdata_size_o !== 2'b00 || if64.packet_waddr_o !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_values: cnt %0d size %b addr %0d expected all 0",
                     dcnt64, if64.packet_wdata_size_o, if64.packet_waddr_o);
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (if64.packet_wdata_size_o !== 2'b11) begin
            tests_failed++;
            $display("FAIL wdata_size_64: got %b expected 11", if64.packet_wdata_size_o);
        end
        tests_run++;
        if (if32.packet_wdata_size_o !== 2'b10) begin
            tests_failed++;
            $display("FAIL wdata_size_32: got %b expected 10", if32.packet_wdata_size_o);
        end
    endtask

    task automatic test_basic();
        int b0 = wa64_q.size();
        int w0 = ws64_q.size();
        int s0 = send64;
        logic [63:0] w;
        drive_frame(60, 8'h00, 1'b0, 2);
        tests_run++;
        if (wa64_q.size() - b0 != 8) begin
            tests_failed++;
            $display("FAIL basic_wr_count: got %0d expected 8", wa64_q.size() - b0);
        end
        for (int k = 0; k < 8; k++) begin
            tests_run++;
            if (wa64_q[b0 + k] != 8 * k) begin
                tests_failed++;
                $display("FAIL basic_waddr%0d: got %0d expected %0d", k, wa64_q[b0 + k], 8 * k);
            end
        end
        tests_run++;
        if (wd64_q[b0] !== 64'h0706050403020100) begin
            tests_failed++;
            $display("FAIL basic_word0: got %h expected 0706050403020100", wd64_q[b0]);
        end
        tests_run++;
        if (wd64_q[b0 + 1] !== 64'h0F0E0D0C0B0A0908) begin
            tests_failed++;
            $display("FAIL basic_word1: got %h expected 0f0e0d0c0b0a0908", wd64_q[b0 + 1]);
        end
        w = wd64_q[b0 + 7];
        tests_run++;
        if (w[31:0] !== 32'h3B3A3938) begin
            tests_failed++;
            $display("FAIL basic_last_word: got %h expected 3b3a3938", w[31:0]);
        end
        tests_run++;
        if (ws64_q.size() - w0 != 1 || ws64_q[w0] != 60) begin
            tests_failed++;
            $display("FAIL basic_wsize: got %0d entries, value %0d expected 1 entry of 60",
                     ws64_q.size() - w0, ws64_q[w0]);
        end
        tests_run++;
        if (send64 - s0 != 1 || send_cyc64 != last_cyc + 1 || badcommit64 != 0) begin
            tests_failed++;
            $display("FAIL basic_send: got %0d sends at cyc %0d (bad %0d) expected 1 at cyc %0d",
                     send64 - s0, send_cyc64, badcommit64, last_cyc + 1);
        end
    endtask

    task automatic test_no_req();
        int b0 = wa64_q.size();
        int s0 = send64;
        int d0 = dropp64;
        req = 1'b0;
        drive_frame(64, 8'h10, 1'b0, 2);
        req = 1'b1;
        tests_run++;
        if (wa64_q.size() != b0 || send64 != s0) begin
            tests_failed++;
            $display("FAIL noreq_writes: got %0d writes %0d sends expected 0 0", wa64_q.size() - b0, send64 - s0);
        end
        tests_run++;
        if (dropp64 - d0 != 1 || dcnt64 !== 16'd1) begin
            tests_failed++;
            $display("FAIL noreq_drop: got %0d pulses count %0d expected 1 1", dropp64 - d0, dcnt64);
        end
    endtask

    task automatic test_error_last();
        int b0 = wa64_q.size();
        int w0 = ws64_q.size();
        int s0 = send64;
        drive_frame(64, 8'h40, 1'b1, 2);
        tests_run++;
        if (wa64_q.size() - b0 != 7 || wa64_q[b0 + 6] != 48) begin
            tests_failed++;
            $display("FAIL err_writes: got %0d writes last addr %0d expected 7 writes last 48",
                     wa64_q.size() - b0, wa64_q[wa64_q.size() - 1]);
        end
        tests_run++;
        if (ws64_q.size() != w0 || send64 != s0 || dcnt64 !== 16'd2) begin
            tests_failed++;
            $display("FAIL err_commit: got %0d wsize %0d send count %0d expected 0 0 2",
                     ws64_q.size() - w0, send64 - s0, dcnt64);
        end
    endtask

    task automatic test_max_len();
        int b0 = wa64_q.size();
        int w0 = ws64_q.size();
        int s0 = send64;
        drive_frame(2048, 8'h00, 1'b0, 2);
        tests_run++;
        if (wa64_q.size() - b0 != 256 || wa64_q[b0 + 255] != 2040) begin
            tests_failed++;
            $display("FAIL max_writes: got %0d writes last addr %0d expected 256 last 2040",
                     wa64_q.size() - b0, wa64_q[wa64_q.size() - 1]);
        end
        tests_run++;
        if (ws64_q.size() - w0 != 1 || ws64_q[w0] != 2048 || send64 - s0 != 1) begin
            tests_failed++;
            $display("FAIL max_commit: got wsize %0d sends %0d expected 2048 1", ws64_q[w0], send64 - s0);
        end
        b0 = wa64_q.size();
        w0 = ws64_q.size();
        s0 = send64;
        drive_frame(2049, 8'h00, 1'b0, 2);
        tests_run++;
        if (ws64_q.size() != w0 || send64 != s0 || dcnt64 !== 16'd3) begin
            tests_failed++;
            $display("FAIL oversize: got %0d wsize %0d sends count %0d expected 0 0 3",
                     ws64_q.size() - w0, send64 - s0, dcnt64);
        end
        tests_run++;
        if (wa64_q.size() - b0 != 256) begin
            tests_failed++;
            $display("FAIL oversize_writes: got %0d expected 256", wa64_q.size() - b0);
        end
    endtask

    task automatic test_back_to_back();
        int s0 = send64;
        int d0 = dropp64;
        drive_frame(8, 8'h20, 1'b0, 0);
        drive_frame(8, 8'h30, 1'b0, 2);
        tests_run++;
        if (send64 - s0 != 1 || dropp64 - d0 != 1) begin
            tests_failed++;
            $display("FAIL b2b_nogap: got %0d sends %0d drops expected 1 1", send64 - s0, dropp64 - d0);
        end
        s0 = send64;
        d0 = dropp64;
        drive_frame(8, 8'h20, 1'b0, 1);
        drive_frame(8, 8'h30, 1'b0, 2);
        tests_run++;
        if (send64 - s0 != 2 || dropp64 != d0) begin
            tests_failed++;
            $display("FAIL b2b_gap1: got %0d sends %0d drops expected 2 0", send64 - s0, dropp64 - d0);
        end
    endtask

    task automatic test_reset_mid();
        int s0 = send64;
        int b0;
        int w0;
        int d0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            rx_valid = 1'b1;
            rx_data  = 8'(i);
            rx_last  = 1'b0;
            rx_error = 1'b0;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        b0 = wa64_q.size();
        w0 = ws64_q.size();
        d0 = dropp64;
        tests_run++;
        if (send64 != s0 || dcnt64 !== 16'd0) begin
            tests_failed++;
            $display("FAIL rstmid_abandon: got %0d sends count %0d expected 0 0", send64 - s0, dcnt64);
        end
        drive_frame(64, 8'h80, 1'b0, 2);
        tests_run++;
        if (wa64_q.size() - b0 != 8 || wa64_q[b0] != 0) begin
            tests_failed++;
            $display("FAIL rstmid_writes: got %0d writes first addr %0d expected 8 at 0", wa64_q.size() - b0, wa64_q[b0]);
        end
        tests_run++;
        if (send64 - s0 != 1 || ws64_q[w0] != 64 || dcnt64 !== 16'd0 || dropp64 != d0) begin
            tests_failed++;
            $display("FAIL rstmid_commit: got sends %0d wsize %0d count %0d expected 1 64 0",
                     send64 - s0, ws64_q[w0], dcnt64);
        end
    endtask

    task automatic test_dw32();
        int b0 = wa32_q.size();
        int w0 = ws32_q.size();
        int s0 = send32;
        logic [31:0] w;
        drive_frame(5, 8'hA1, 1'b0, 2);
        tests_run++;
        if (wa32_q.size() - b0 != 2 || wa32_q[b0] != 0 || wa32_q[b0 + 1] != 4) begin
            tests_failed++;
            $display("FAIL dw32_addr: got %0d writes addrs %0d %0d expected 2 writes 0 4",
                     wa32_q.size() - b0, wa32_q[b0], wa32_q[b0 + 1]);
        end
        tests_run++;
        if (wd32_q[b0] !== 32'hA4A3A2A1) begin
            tests_failed++;
            $display("FAIL dw32_word0: got %h expected a4a3a2a1", wd32_q[b0]);
        end
        w = wd32_q[b0 + 1];
        tests_run++;
        if (w[7:0] !== 8'hA5) begin
            tests_failed++;
            $display("FAIL dw32_word1: got %h expected a5", w[7:0]);
        end
        tests_run++;
        if (ws32_q.size() - w0 != 1 || ws32_q[w0] != 5 || send32 - s0 != 1) begin
            tests_failed++;
            $display("FAIL dw32_commit: got wsize %0d sends %0d expected 5 1", ws32_q[w0], send32 - s0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_req();
        test_error_last();
        test_max_len();
        test_back_to_back();
        test_reset_mid();
        test_dw32();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
